// File: rtl/audio_clk_pkg.sv
// Shared constants and divisor helpers for the audio clock-enable generator.
// All rates derive from the 24.576 MHz master clock.
package audio_clk_pkg;

  localparam int MASTER_HZ  = 24_576_000;
  localparam int DIV_SAMPLE = 512;
  localparam int DIV_BIT    = 16;
  localparam int CNT_W_DEF  = 10;

  typedef logic [CNT_W_DEF-1:0] div_t;

  function automatic logic div_ok(div_t d);
    return |d;
  endfunction

endpackage

// File: rtl/audio_clk_en_chan.sv
// One enable channel: counter, active/pending divisor, busy flag, enable flop.
// Optional square-wave output under AUDIO_CLK_EN_GEN_TOGGLE_EN.
module audio_clk_en_chan
  import audio_clk_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_SAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync_req,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             en,
  output logic             busy
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
  ,
  output logic             tgl
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] nxt_div;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             wrap;
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
  logic             tgl_q, tgl_d;
`endif

  // A write in the reload cycle itself beats the older pending value.
  always_comb begin
    wrap    = run && (cnt_q == div_q - ONE);
    nxt_div = wr ? wr_val : (busy_q ? pend_q : div_q);
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
    tgl_d   = tgl_q;
`endif
    if (sync_req) begin
      cnt_d  = '0;
      div_d  = nxt_div;
      busy_d = 1'b0;
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
      tgl_d  = 1'b0;
`endif
    end else if (wrap) begin
      cnt_d  = '0;
      div_d  = nxt_div;
      busy_d = 1'b0;
      en_d   = 1'b1;
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
      tgl_d  = ~tgl_q;
`endif
    end else begin
      if (run) begin
        cnt_d = cnt_q + ONE;
      end
      if (wr) begin
        pend_d = wr_val;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      pend_q <= '0;
      busy_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      en_q   <= en_d;
    end
  end

`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  assign tgl = tgl_q;
`endif

  assign en   = en_q;
  assign busy = busy_q;

endmodule

// File: rtl/audio_clk_en_gen.sv
// N-channel audio clock-enable generator with glitch-free divisor reloads.
// Define AUDIO_CLK_EN_GEN_TOGGLE_EN to add the clk_tgl square-wave outputs.
module audio_clk_en_gen
  import audio_clk_pkg::*;
#(
  parameter int                      NUM_CH  = 2,
  parameter int                      CNT_W   = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV =
    {CNT_W'(DIV_BIT), CNT_W'(DIV_SAMPLE)},
  localparam int                     CH_W    =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sync_req,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] div_busy,
  output logic              div_err,
  output logic [NUM_CH-1:0] clk_en
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0] clk_tgl
`endif
);

  logic              val_ok;
  logic              ch_ok;
  logic              wr_ok;
  logic              err_d, err_q;
  logic [NUM_CH-1:0] wr_hit;

  // Wider-than-default counters fall back to a plain reduction.
  always_comb begin
    val_ok = (CNT_W <= CNT_W_DEF) ? div_ok(div_t'(div_val))
                                  : (|div_val);
    ch_ok  = int'(div_ch) < NUM_CH;
    wr_ok  = div_wr && val_ok && ch_ok;
    err_d  = div_wr && !(val_ok && ch_ok);
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_ok && (int'(div_ch) == i);
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign div_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    audio_clk_en_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk     (master_clk),
      .rst     (rst),
      .run     (run),
      .sync_req(sync_req),
      .wr      (wr_hit[i]),
      .wr_val  (div_val),
      .en      (clk_en[i]),
      .busy    (div_busy[i])
`ifdef AUDIO_CLK_EN_GEN_TOGGLE_EN
      ,
      .tgl     (clk_tgl[i])
`endif
    );
  end

endmodule
